// File: rtl/moxie_wb_pkg.sv
// Shared Wishbone constants and arbiter state encoding for the moxie SoC bus.
package moxie_wb_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 16;
    localparam int WB_SW = 2;

    localparam logic [WB_DW-1:0] TIMEOUT_DATA = 16'hDEAD;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    function automatic logic [1:0] gnt_of(arb_state_e st);
        case (st)
            ST_OWN0: return 2'b01;
            ST_OWN1: return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/wb_master_arb_if.sv
// Classic Wishbone bus bundle; dat_w flows master->slave, dat_r slave->master.
interface wb_master_arb_if;
    import moxie_wb_pkg::*;

    logic [WB_AW-1:0] adr;
    logic [WB_DW-1:0] dat_w;
    logic [WB_DW-1:0] dat_r;
    logic [WB_SW-1:0] sel;
    logic             we;
    logic             cyc;
    logic             stb;
    logic             ack;

    modport master (output adr, dat_w, sel, we, cyc, stb, input dat_r, ack);
    modport slave  (input adr, dat_w, sel, we, cyc, stb, output dat_r, ack);

endinterface

// File: rtl/wb_arb_timer.sv
// Counts consecutive stalled strobe cycles and pulses expire_o on the LIMIT-th one.
module wb_arb_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);
    localparam int unsigned    CW   = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CW-1:0] LAST = (LIMIT > 0) ? CW'(LIMIT - 1) : '0;

    logic [CW-1:0] cnt_q, cnt_d;

    // Expiry is decided from the count alone so it never depends on the slave ack.
    assign expire_o = (LIMIT != 0) && en_i && (cnt_q == LAST);
    assign cnt_d    = (!en_i || clr_i || expire_o) ? '0 : cnt_q + CW'(1);

    always_ff @(posedge clk_i) begin
        if (!rst_i) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/wb_master_arb.sv
// Two-master Wishbone arbiter: registered grant, cycle lock, RR/fixed priority, ack timeout.
module wb_master_arb
    import moxie_wb_pkg::*;
#(
    parameter bit               PRIO_M1 = 1'b1,
    parameter int unsigned      TIMEOUT = 255,
    parameter logic [WB_DW-1:0] TO_DATA = TIMEOUT_DATA
) (
    input  logic              clk_i,
    input  logic              rst_i,
    wb_master_arb_if.slave    m0,
    wb_master_arb_if.slave    m1,
    wb_master_arb_if.master   s,
    output logic [1:0]        gnt_o,
    output logic              timeout_o
);
    arb_state_e       state_q, state_d;
    logic [1:0]       gnt_q;
    logic             last_m1_q, last_m1_d;
    logic             late_q;

    logic             own0, own1;
    logic [WB_AW-1:0] mst_adr;
    logic [WB_DW-1:0] mst_dat;
    logic [WB_SW-1:0] mst_sel;
    logic             mst_we, mst_cyc, mst_stb;
    logic             expire, s_stb, ack_ok, resp_ack;
    logic [WB_DW-1:0] resp_dat;

    assign own0 = (state_q == ST_OWN0);
    assign own1 = (state_q == ST_OWN1);

    always_comb begin
        mst_adr = '0;
        mst_dat = '0;
        mst_sel = '0;
        mst_we  = 1'b0;
        mst_cyc = 1'b0;
        mst_stb = 1'b0;
        if (own0) begin
            mst_adr = m0.adr;
            mst_dat = m0.dat_w;
            mst_sel = m0.sel;
            mst_we  = m0.we;
            mst_cyc = m0.cyc;
            mst_stb = m0.stb;
        end else if (own1) begin
            mst_adr = m1.adr;
            mst_dat = m1.dat_w;
            mst_sel = m1.sel;
            mst_we  = m1.we;
            mst_cyc = m1.cyc;
            mst_stb = m1.stb;
        end
    end

    wb_arb_timer #(.LIMIT(TIMEOUT)) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (mst_stb),
        .clr_i    (ack_ok),
        .expire_o (expire)
    );

    // A forced termination kills the strobe; an ack straggling in right after it is dropped.
    assign s_stb    = mst_stb & ~expire;
    assign ack_ok   = s.ack & s_stb & ~late_q;
    assign resp_ack = expire | ack_ok;
    assign resp_dat = expire ? TO_DATA : s.dat_r;

    assign s.adr   = mst_adr;
    assign s.dat_w = mst_dat;
    assign s.sel   = mst_sel;
    assign s.we    = mst_we;
    assign s.cyc   = mst_cyc & ~expire;
    assign s.stb   = s_stb;

    assign m0.ack   = own0 & resp_ack;
    assign m0.dat_r = own0 ? resp_dat : '0;
    assign m1.ack   = own1 & resp_ack;
    assign m1.dat_r = own1 ? resp_dat : '0;

    assign gnt_o     = gnt_q;
    assign timeout_o = expire;

    always_comb begin
        state_d   = state_q;
        last_m1_d = last_m1_q;
        unique case (state_q)
            ST_IDLE: begin
                if (m0.cyc && m1.cyc)
                    state_d = (PRIO_M1 || !last_m1_q) ? ST_OWN1 : ST_OWN0;
                else if (m0.cyc)
                    state_d = ST_OWN0;
                else if (m1.cyc)
                    state_d = ST_OWN1;
            end
            // Release hands straight to a waiting master, no idle bubble.
            ST_OWN0: if (!m0.cyc) begin
                state_d   = m1.cyc ? ST_OWN1 : ST_IDLE;
                last_m1_d = 1'b0;
            end
            ST_OWN1: if (!m1.cyc) begin
                state_d   = m0.cyc ? ST_OWN0 : ST_IDLE;
                last_m1_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 2'b00;
            last_m1_q <= 1'b1;
            late_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_of(state_d);
            last_m1_q <= last_m1_d;
            late_q    <= expire;
        end
    end

endmodule

// File: tb/tb_wb_master_arb.sv
// Bench for wb_master_arb: round-robin and fixed-priority instances against a cycle model.
module tb_wb_master_arb;
    import moxie_wb_pkg::*;

    localparam int TO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n = 1'b0;
    logic [1:0]       m_cyc = '0, m_stb = '0, m_we = '0;
    logic [1:0][31:0] m_adr = '0;
    logic [1:0][15:0] m_dat = '0;
    logic [1:0][1:0]  m_sel = '0;
    logic             s_ack = 1'b0;
    logic [15:0]      s_dat = '0;

    logic [1:0][52:0] s_w;
    logic [1:0][16:0] m0_w, m1_w;
    logic [1:0][1:0]  gnt_w;
    logic [1:0]       tmo_w;

    wb_master_arb_if m0_b [2] ();
    wb_master_arb_if m1_b [2] ();
    wb_master_arb_if s_b  [2] ();

    // Instance 0 is round-robin, instance 1 is fixed m1 priority; both see identical stimulus.
    for (genvar k = 0; k < 2; k++) begin : g_dut
        assign m0_b[k].adr   = m_adr[0];
        assign m0_b[k].dat_w = m_dat[0];
        assign m0_b[k].sel   = m_sel[0];
        assign m0_b[k].we    = m_we[0];
        assign m0_b[k].cyc   = m_cyc[0];
        assign m0_b[k].stb   = m_stb[0];
        assign m1_b[k].adr   = m_adr[1];
        assign m1_b[k].dat_w = m_dat[1];
        assign m1_b[k].sel   = m_sel[1];
        assign m1_b[k].we    = m_we[1];
        assign m1_b[k].cyc   = m_cyc[1];
        assign m1_b[k].stb   = m_stb[1];
        assign s_b[k].dat_r  = s_dat;
        assign s_b[k].ack    = s_ack;

        assign s_w[k]  = {s_b[k].adr, s_b[k].dat_w, s_b[k].sel, s_b[k].we, s_b[k].cyc, s_b[k].stb};
        assign m0_w[k] = {m0_b[k].ack, m0_b[k].dat_r};
        assign m1_w[k] = {m1_b[k].ack, m1_b[k].dat_r};

        wb_master_arb #(.PRIO_M1(k == 1), .TIMEOUT(TO), .TO_DATA(16'hDEAD)) u_dut (
            .clk_i     (clk),
            .rst_i     (rst_n),
            .m0        (m0_b[k]),
            .m1        (m1_b[k]),
            .s         (s_b[k]),
            .gnt_o     (gnt_w[k]),
            .timeout_o (tmo_w[k])
        );
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: owner -1/0/1, last owner, stalled-strobe count, late-ack flag.
    int   own [2] = '{-1, -1};
    int   last[2] = '{1, 1};
    int   cnt [2] = '{0, 0};
    bit   late[2] = '{0, 0};

    logic [52:0] e_s;
    logic [16:0] e_m0, e_m1;
    logic [1:0]  e_g;
    logic        e_t, e_exp, e_ack;

    task automatic model_eval(input int k);
        int   o;
        logic sstb;
        logic [16:0] resp;
        o = own[k];
        e_s = '0; e_m0 = '0; e_m1 = '0; e_g = '0; e_t = 0; e_exp = 0; e_ack = 0;
        if (o >= 0) begin
            e_exp = m_stb[o] && (cnt[k] == TO - 1);
            sstb  = m_stb[o] && !e_exp;
            e_s   = {m_adr[o], m_dat[o], m_sel[o], m_we[o], m_cyc[o] && !e_exp, sstb};
            e_ack = s_ack && sstb && !late[k];
            resp  = {e_exp || e_ack, e_exp ? 16'hDEAD : s_dat};
            if (o == 0) e_m0 = resp;
            else        e_m1 = resp;
            e_g = (o == 0) ? 2'b01 : 2'b10;
            e_t = e_exp;
        end
    endtask

    task automatic model_update(input int k);
        int o;
        model_eval(k);
        o = own[k];
        if (!rst_n) begin
            own[k] = -1; last[k] = 1; cnt[k] = 0; late[k] = 0;
            return;
        end
        late[k] = e_exp;
        cnt[k]  = (o >= 0 && m_stb[o] && !e_ack && !e_exp) ? cnt[k] + 1 : 0;
        if (o < 0) begin
            if (m_cyc[0] && m_cyc[1]) own[k] = (k == 1) ? 1 : (last[k] == 1 ? 0 : 1);
            else if (m_cyc[0])        own[k] = 0;
            else if (m_cyc[1])        own[k] = 1;
        end else if (!m_cyc[o]) begin
            last[k] = o;
            own[k]  = m_cyc[1-o] ? 1 - o : -1;
        end
    endtask

    // One clock: compare every output against the model mid-cycle, then advance both.
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            model_eval(k);
            chk($sformatf("s_bus%0d", k), 64'(s_w[k]),  64'(e_s));
            chk($sformatf("m0_rsp%0d", k), 64'(m0_w[k]), 64'(e_m0));
            chk($sformatf("m1_rsp%0d", k), 64'(m1_w[k]), 64'(e_m1));
            chk($sformatf("gnt%0d", k),    64'(gnt_w[k]), 64'(e_g));
            chk($sformatf("tmo%0d", k),    64'(tmo_w[k]), 64'(e_t));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_update(k);
        #1;
    endtask

    task automatic idle_masters();
        m_cyc = '0; m_stb = '0; s_ack = 1'b0;
    endtask

    initial begin
        int seq[$];
        bit acked[2];
        int first;

        step(); step();
        rst_n = 1'b1;
        step();
        chk("rst_gnt", 64'(gnt_w[0]), 64'(2'b00));

        // Simultaneous request from idle, then m0 holds 3 beats while m1 waits on the RR instance.
        m_cyc = 2'b11; m_stb = 2'b11;
        m_adr[0] = 32'h1000_0000; m_adr[1] = 32'h2000_0000;
        m_sel[0] = 2'b11; m_sel[1] = 2'b01;
        step();
        chk("tie_rr", 64'(gnt_w[0]), 64'(2'b01));
        chk("tie_pr", 64'(gnt_w[1]), 64'(2'b10));
        chk("stb_rr", 64'(s_w[0][0]), 64'(1));
        chk("adr_rr", 64'(s_w[0][52:21]), 64'(32'h1000_0000));
        s_ack = 1'b1; s_dat = 16'h1234;
        for (int b = 0; b < 3; b++) begin
            #1;
            chk("lock_gnt", 64'(gnt_w[0]), 64'(2'b01));
            chk("lock_ack0", 64'(m0_w[0]), 64'({1'b1, 16'h1234}));
            chk("lock_ack1", 64'(m1_w[0]), 64'(0));
            step();
        end
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        step();
        chk("handoff", 64'(gnt_w[0]), 64'(2'b10));
        idle_masters();
        step(); step();

        // Single request after idle.
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1; m_dat[0] = 16'h5A5A;
        step();
        chk("single_gnt", 64'(gnt_w[0]), 64'(2'b01));
        idle_masters(); m_we = '0;
        step(); step();

        // Ack timeout on m1, then a late ack that must not reach m1.
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h3000_0040;
        step();
        step(); step(); step();
        for (int k = 0; k < 2; k++) begin
            chk("to_rsp", 64'(m1_w[k]), 64'({1'b1, 16'hDEAD}));
            chk("to_pulse", 64'(tmo_w[k]), 64'(1));
            chk("to_cyc", 64'(s_w[k][1]), 64'(0));
        end
        step();
        s_ack = 1'b1; s_dat = 16'hBEEF;
        #1;
        chk("late_ack", 64'(m1_w[0][16]), 64'(0));
        step();
        idle_masters();
        step(); step();

        // Reset while m0 is mid-transfer with an ack on the bus.
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        step();
        rst_n = 1'b0; s_ack = 1'b1;
        step();
        chk("rst_gnt", 64'(gnt_w[0]), 64'(2'b00));
        chk("rst_cyc", 64'(s_w[0][1]), 64'(0));
        chk("rst_ack", 64'(m0_w[0][16]), 64'(0));
        rst_n = 1'b1; idle_masters();
        step(); step();

        // Round-robin: both masters issue single-beat cycles back to back.
        first = (last[0] == 1) ? 0 : 1;
        acked = '{0, 0};
        for (int i = 0; i < 24; i++) begin
            m_cyc = {!acked[1], !acked[0]};
            m_stb = m_cyc;
            s_ack = 1'b1;
            #1;
            acked[0] = m0_w[0][16];
            acked[1] = m1_w[0][16];
            if (acked[0]) seq.push_back(0);
            if (acked[1]) seq.push_back(1);
            step();
        end
        for (int i = 0; i < 8; i++)
            chk("rr_owner", 64'(i < seq.size() ? seq[i] : -1), 64'(first ^ (i & 1)));
        idle_masters();
        step(); step();

        // Random traffic with occasional resets and long slave stalls.
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(199) != 0);
            for (int m = 0; m < 2; m++) begin
                if (m_cyc[m]) m_cyc[m] = ($urandom_range(5) != 0);
                else          m_cyc[m] = ($urandom_range(2) == 0);
                m_stb[m] = m_cyc[m] && ($urandom_range(3) != 0);
                m_adr[m] = $urandom;
                m_dat[m] = 16'($urandom);
                m_sel[m] = 2'($urandom);
                m_we[m]  = 1'($urandom);
            end
            s_ack = ($urandom_range(3) == 0);
            s_dat = 16'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_master_arb.md
Name: wb_master_arb

Overview:
Two-master Wishbone (classic, 16-bit data, 32-bit address) arbiter that sits between the masters and the single master port of wb_intercon. Master 0 is the moxielite_wb core; master 1 is the gdbte_uart debug master, whose bus outputs are currently unconnected. It adds registered grant, cycle-level bus locking, round-robin or fixed priority, and a per-transfer ack timeout, so the debugger can peek and poke memory and peripherals while the core runs.

Parameters:
PRIO_M1, 1, 1 = master 1 wins simultaneous requests from IDLE; 0 = round-robin (last owner loses the tie).
TIMEOUT, 255, cycles of stb-without-ack before the arbiter forces termination; 0 disables the timeout.
TO_DATA, 16'hDEAD, read data returned to the owner on a forced termination.

Ports:
clk_i  in  1  system clock (clk_cpu)
rst_i  in  1  synchronous, active-low reset (0 = reset); sampled on rising clk_i only
m0_adr_i  in  32  / m0_dat_i in 16 / m0_sel_i in 2 / m0_we_i in 1 / m0_cyc_i in 1 / m0_stb_i in 1: core request
m0_dat_o  out  16  / m0_ack_o out 1: core response
m1_adr_i  in  32  / m1_dat_i in 16 / m1_sel_i in 2 / m1_we_i in 1 / m1_cyc_i in 1 / m1_stb_i in 1: debugger request
m1_dat_o  out  16  / m1_ack_o out 1: debugger response
s_adr_o  out  32  / s_dat_o out 16 / s_sel_o out 2 / s_we_o out 1 / s_cyc_o out 1 / s_stb_o out 1: to wb_intercon master side
s_dat_i  in  16  / s_ack_i in 1: from wb_intercon
gnt_o  out  2  one-hot current owner (00 = idle)
timeout_o  out  1  one-cycle pulse on forced termination

Behaviour:
- FSM states: IDLE, OWN0, OWN1. Grant is a register. Request for master n = mn_cyc_i.
- IDLE: no request -> stay. One request -> OWNn next cycle. Both -> PRIO_M1=1 gives OWN1; otherwise the master that was not last owner wins. Last owner resets to m1.
- OWNn: s_adr/dat/sel/we/cyc/stb_o are combinationally muxed from master n. Non-owner ack_o = 0. Non-owner dat_o = 0. Owner dat_o = s_dat_i; owner ack_o = s_ack_i & mn_stb_i.
- Grant latency: the first stb reaches the slave 1 cycle after cyc rises (IDLE to OWN). Back-to-back beats under a held cyc add no extra latency.
- Lock: the owner keeps the grant while mn_cyc_i = 1, including across multiple stb/ack beats. It is never preempted.
- Release: mn_cyc_i = 0 in OWNn -> if the other master requests, go directly to OWN(other) next cycle with no IDLE bubble; else go to IDLE. Update last owner on release.
- Timeout: a counter (width clog2(TIMEOUT+1)) clears when stb is low or ack is seen, and increments while the owner's stb = 1 and s_ack_i = 0. When it reaches TIMEOUT:
  - pulse owner ack_o with dat_o = TO_DATA for that cycle;
  - pulse timeout_o;
  - force s_stb_o = 0 and s_cyc_o = 0 for that cycle;
  - clear the counter; the grant is retained until cyc drops.
- A late s_ack_i that arrives in the cycle after a forced termination is dropped; it is not forwarded.
- s_ack_i is ignored when s_stb_o = 0.
- Reset (rst_i = 0 at clk edge), including mid-transfer:
  - state = IDLE, counter = 0, last owner = m1;
  - all s_* outputs 0, both ack_o = 0, both dat_o = 0, gnt_o = 00, timeout_o = 0;
  - an in-flight slave ack is discarded.
- Master dropping stb while keeping cyc: the grant is held and the counter clears.

Decomposition:
- Shared package moxie_wb_pkg: constants WB_AW = 32, WB_DW = 16, WB_SW = 2; the state enum (IDLE/OWN0/OWN1) as localparams; TIMEOUT_DATA default.
- One natural sub-module: wb_arb_timer, the stb/ack timeout counter with enable, clear and expire pulse, reusable by wb_watchdog.
- Muxing and FSM stay in the top.

Test Plan:
- Reset then single request: m0 cyc/stb with adr = 0x1000_0000 -> gnt_o = 01 after 1 cycle, s_stb_o = 1 with s_adr_o = 0x1000_0000; s_ack_i with dat 0x1234 -> m0_ack_o = 1, m0_dat_o = 0x1234; m1_ack_o = 0.
- Simultaneous request from IDLE, PRIO_M1 = 1 -> gnt_o = 10. With PRIO_M1 = 0 and last owner m1 -> gnt_o = 01.
- Lock and handoff: m0 holds cyc for 3 beats while m1 requests -> gnt stays 01 for all 3 acks; on the cycle m0_cyc drops, gnt_o = 10 the next cycle with no IDLE cycle.
- Timeout with TIMEOUT = 4: m1 stb, no s_ack_i -> on the 4th stalled cycle m1_ack_o = 1, m1_dat_o = 0xDEAD, timeout_o = 1, s_cyc_o = 0; a s_ack_i injected on the next cycle is not seen by m1.
- Reset mid-transfer: rst_i = 0 while OWN0 with stb high -> the next cycle shows gnt_o = 00, s_cyc_o = 0, m0_ack_o = 0, even if s_ack_i = 1.
- Round-robin fairness (PRIO_M1 = 0): both masters issue continuous single-beat cycles, dropping cyc after each ack -> gnt_o alternates 01/10 for 8 transfers.
